// File: rtl/ddr5_cmd_receiver.sv
// DDR5 two-cycle command decoder: per-bank open/timer tracking, protocol and timing
// error reporting, and fixed-latency read/write response delay lines.

module ddr5_bank_timer #(
    parameter int TW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          busy
);
    logic [TW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset)           cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - TW'(1);
    end

    assign busy = (cnt != '0);
endmodule

module ddr5_cmd_receiver #(
    parameter int TRCD = 4,
    parameter int TRP  = 4,
    parameter int TRFC = 16,
    parameter int TCL  = 6,
    parameter int TCWL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    input  logic [2:0]  bank_group,
    input  logic [1:0]  bank,
    input  logic [15:0] row,
    input  logic [9:0]  col,
    output logic [31:0] open_mask,
    output logic        rd_valid,
    output logic [2:0]  rd_bank_group,
    output logic [1:0]  rd_bank,
    output logic [15:0] rd_row,
    output logic [9:0]  rd_col,
    output logic        wr_ack,
    output logic [2:0]  wr_bank_group,
    output logic [1:0]  wr_bank,
    output logic        err_valid,
    output logic [2:0]  err_code
);
    localparam int TMAX = (TRFC > TRCD) ? ((TRFC > TRP) ? TRFC : TRP)
                                        : ((TRCD > TRP) ? TRCD : TRP);
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [2:0] ACT0 = 3'd0, ACT1 = 3'd1, RD0 = 3'd2, RD1 = 3'd3,
                           WR0  = 3'd4, WR1  = 3'd5, PRE = 3'd6, REF = 3'd7;

    typedef enum logic [1:0] {IDLE, WAIT_ACT1, WAIT_RD1, WAIT_WR1} state_t;
    typedef struct packed {
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [9:0]  col;
    } rd_resp_t;
    typedef struct packed {
        logic [2:0] bg;
        logic [1:0] bank;
    } wr_resp_t;

    state_t        state, state_nxt;
    logic [2:0]    lat_bg, second_cmd, err_nxt;
    logic [1:0]    lat_bank;
    logic [15:0]   lat_row;
    logic [9:0]    lat_col;
    logic [4:0]    idx, lat_idx;
    logic [15:0]   row_mem [32];
    logic [31:0]   busy, tmr_load;
    logic [TW-1:0] tmr_val;
    logic          capture, do_act1, do_rd1, do_wr1, do_pre, do_ref, err_now;

    logic [TCL:1]             rd_vld_pipe;
    rd_resp_t [TCL:1]         rd_pipe;
    logic [TCWL:1]            wr_vld_pipe;
    wr_resp_t [TCWL:1]        wr_pipe;

    assign idx     = {bank_group, bank};
    assign lat_idx = {lat_bg, lat_bank};

    always_comb begin
        case (state)
            WAIT_ACT1: second_cmd = ACT1;
            WAIT_RD1:  second_cmd = RD1;
            default:   second_cmd = WR1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        do_act1   = 1'b0;
        do_rd1    = 1'b0;
        do_wr1    = 1'b0;
        do_pre    = 1'b0;
        do_ref    = 1'b0;
        err_now   = 1'b0;
        err_nxt   = 3'd0;
        case (state)
            IDLE: if (cmd_valid) begin
                case (cmd)
                    ACT0: begin
                        if (open_mask[idx])  begin err_now = 1'b1; err_nxt = 3'd2; end
                        else if (busy[idx])  begin err_now = 1'b1; err_nxt = 3'd5; end
                        else begin capture = 1'b1; state_nxt = WAIT_ACT1; end
                    end
                    RD0, WR0: begin
                        if (!open_mask[idx]) begin err_now = 1'b1; err_nxt = 3'd3; end
                        else if (busy[idx])  begin err_now = 1'b1; err_nxt = 3'd4; end
                        else begin
                            capture   = 1'b1;
                            state_nxt = (cmd == RD0) ? WAIT_RD1 : WAIT_WR1;
                        end
                    end
                    // PRE to a closed bank is a silent no-op and leaves its timer alone
                    PRE: do_pre = open_mask[idx];
                    REF: begin
                        if (|open_mask) begin err_now = 1'b1; err_nxt = 3'd6; end
                        else do_ref = 1'b1;
                    end
                    default: begin err_now = 1'b1; err_nxt = 3'd1; end
                endcase
            end
            default: begin
                state_nxt = IDLE;
                if (cmd_valid && cmd == second_cmd && idx == lat_idx) begin
                    do_act1 = (state == WAIT_ACT1);
                    do_rd1  = (state == WAIT_RD1);
                    do_wr1  = (state == WAIT_WR1);
                end else begin
                    err_now = 1'b1;
                    err_nxt = 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            open_mask <= '0;
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            lat_bg    <= '0;
            lat_bank  <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
        end else begin
            state     <= state_nxt;
            err_valid <= err_now;
            if (err_now) err_code <= err_nxt;
            if (capture) begin
                lat_bg   <= bank_group;
                lat_bank <= bank;
                if (cmd == ACT0) lat_row <= row;
                else             lat_col <= col;
            end
            if (do_act1) open_mask[lat_idx] <= 1'b1;
            if (do_pre)  open_mask[idx]     <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (do_act1) row_mem[lat_idx] <= lat_row;
    end

    always_comb begin
        tmr_val = do_ref ? TW'(TRFC) : (do_act1 ? TW'(TRCD) : TW'(TRP));
    end

    for (genvar i = 0; i < 32; i++) begin : g_bank
        assign tmr_load[i] = do_ref | (do_act1 && lat_idx == 5'(i)) | (do_pre && idx == 5'(i));
        ddr5_bank_timer #(.TW(TW)) u_tmr (
            .clock    (clock),
            .reset    (reset),
            .load     (tmr_load[i]),
            .load_val (tmr_val),
            .busy     (busy[i])
        );
    end

    // Payloads enter as zero when idle so the response buses stay quiet after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_pipe <= '0;
            rd_pipe     <= '0;
            wr_vld_pipe <= '0;
            wr_pipe     <= '0;
        end else begin
            rd_vld_pipe[1] <= do_rd1;
            rd_pipe[1]     <= do_rd1 ? {lat_bg, lat_bank, row_mem[lat_idx], lat_col} : '0;
            for (int i = 2; i <= TCL; i++) begin
                rd_vld_pipe[i] <= rd_vld_pipe[i-1];
                rd_pipe[i]     <= rd_pipe[i-1];
            end
            wr_vld_pipe[1] <= do_wr1;
            wr_pipe[1]     <= do_wr1 ? {lat_bg, lat_bank} : '0;
            for (int i = 2; i <= TCWL; i++) begin
                wr_vld_pipe[i] <= wr_vld_pipe[i-1];
                wr_pipe[i]     <= wr_pipe[i-1];
            end
        end
    end

    assign rd_valid      = rd_vld_pipe[TCL];
    assign rd_bank_group = rd_pipe[TCL].bg;
    assign rd_bank       = rd_pipe[TCL].bank;
    assign rd_row        = rd_pipe[TCL].row;
    assign rd_col        = rd_pipe[TCL].col;
    assign wr_ack        = wr_vld_pipe[TCWL];
    assign wr_bank_group = wr_pipe[TCWL].bg;
    assign wr_bank       = wr_pipe[TCWL].bank;
endmodule

// File: tb/tb_ddr5_cmd_receiver.sv
// Scoreboard bench for ddr5_cmd_receiver: directed scenarios plus random command mix
// checked against a per-bank ready-cycle model.

module tb_ddr5_cmd_receiver;
    localparam int TRCD = 4, TRP = 4, TRFC = 16, TCL = 6, TCWL = 4;

    logic        clock = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic [2:0]  cmd = '0, bank_group = '0;
    logic [1:0]  bank = '0;
    logic [15:0] row = '0;
    logic [9:0]  col = '0;
    logic [31:0] open_mask;
    logic        rd_valid, wr_ack, err_valid;
    logic [2:0]  rd_bank_group, wr_bank_group, err_code;
    logic [1:0]  rd_bank, wr_bank;
    logic [15:0] rd_row;
    logic [9:0]  rd_col;

    ddr5_cmd_receiver #(.TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TCL(TCL), .TCWL(TCWL)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .bank_group(bank_group), .bank(bank), .row(row), .col(col),
        .open_mask(open_mask),
        .rd_valid(rd_valid), .rd_bank_group(rd_bank_group), .rd_bank(rd_bank),
        .rd_row(rd_row), .rd_col(rd_col),
        .wr_ack(wr_ack), .wr_bank_group(wr_bank_group), .wr_bank(wr_bank),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; logic [2:0] bg; logic [1:0] bk; logic [15:0] row; logic [9:0] col; } rd_exp_t;
    typedef struct { int cyc; logic [2:0] bg; logic [1:0] bk; } wr_exp_t;
    typedef struct { int cyc; logic [2:0] code; } err_exp_t;

    rd_exp_t  rdq[$];
    wr_exp_t  wrq[$];
    err_exp_t errq[$];

    int total = 0, bad = 0;
    bit mon_en = 1'b0;
    logic [31:0] mask_shown = '0;
    logic [2:0]  code_shown = '0;

    // model: open flag, row, and first cycle a new command to the bank is legal
    bit          m_open [32];
    logic [15:0] m_row  [32];
    int          m_ready[32];
    logic [2:0]  m_code = '0;
    bit          p_act = 1'b0;
    logic [2:0]  p_kind;
    logic [4:0]  p_bi;
    logic [15:0] p_row;
    logic [9:0]  p_col;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = m_open[i];
        return m;
    endfunction

    task automatic model(input int n, input bit v, input logic [2:0] c, input logic [4:0] bi,
                         input logic [15:0] r, input logic [9:0] cl);
        int e = 0;
        if (p_act) begin
            p_act = 1'b0;
            if (v && c == p_kind + 3'd1 && bi == p_bi) begin
                case (p_kind)
                    3'd0: begin m_open[p_bi] = 1'b1; m_row[p_bi] = p_row; m_ready[p_bi] = n + TRCD + 1; end
                    3'd2: rdq.push_back('{n + TCL, p_bi[4:2], p_bi[1:0], m_row[p_bi], p_col});
                    default: wrq.push_back('{n + TCWL, p_bi[4:2], p_bi[1:0]});
                endcase
            end else e = 1;
        end else if (v) begin
            case (c)
                3'd0, 3'd2, 3'd4: begin
                    if (c == 3'd0 && m_open[bi])       e = 2;
                    else if (c != 3'd0 && !m_open[bi]) e = 3;
                    else if (n < m_ready[bi])          e = (c == 3'd0) ? 5 : 4;
                    else begin p_act = 1'b1; p_kind = c; p_bi = bi; p_row = r; p_col = cl; end
                end
                3'd6: if (m_open[bi]) begin m_open[bi] = 1'b0; m_ready[bi] = n + TRP + 1; end
                3'd7: begin
                    if (m_mask() != 0) e = 6;
                    else for (int i = 0; i < 32; i++) m_ready[i] = n + TRFC + 1;
                end
                default: e = 1;
            endcase
        end
        if (e != 0) begin
            errq.push_back('{n + 1, 3'(e)});
            m_code = 3'(e);
        end
    endtask

    task automatic step(input bit v, input logic [2:0] c, input logic [4:0] bi,
                        input logic [15:0] r, input logic [9:0] cl);
        @(posedge clock); #1;
        mask_shown = m_mask();
        code_shown = m_code;
        reset = 1'b0; cmd_valid = v; cmd = c; bank_group = bi[4:2]; bank = bi[1:0]; row = r; col = cl;
        model(cyc, v, c, bi, r, cl);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 3'd0, 5'd0, 16'd0, 10'd0);
    endtask

    task automatic do_reset(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clock); #1;
            mask_shown = m_mask();
            code_shown = m_code;
            reset = 1'b1; cmd_valid = 1'b0;
            while (rdq.size() > 0 && rdq[$].cyc > cyc) rdq.pop_back();
            while (wrq.size() > 0 && wrq[$].cyc > cyc) wrq.pop_back();
            while (errq.size() > 0 && errq[$].cyc > cyc) errq.pop_back();
            for (int j = 0; j < 32; j++) begin m_open[j] = 1'b0; m_ready[j] = 0; end
            m_code = '0;
            p_act  = 1'b0;
            if (i >= 1) mon_en = 1'b1;
        end
    endtask

    function automatic logic [4:0] pick_bank(input bit prefer_open);
        logic [4:0] bi = 5'($urandom_range(0, 7));
        if (prefer_open && $urandom_range(0, 9) < 8)
            for (int k = 0; k < 8; k++) if (m_open[(bi + k) % 8]) return 5'((bi + k) % 8);
        return bi;
    endfunction

    always @(negedge clock) if (mon_en) begin
        rd_exp_t re; wr_exp_t we; err_exp_t ee;
        while (rdq.size() > 0 && rdq[0].cyc < cyc) begin chk("rd_cycle", cyc, rdq[0].cyc); rdq.delete(0); end
        while (wrq.size() > 0 && wrq[0].cyc < cyc) begin chk("wr_cycle", cyc, wrq[0].cyc); wrq.delete(0); end
        while (errq.size() > 0 && errq[0].cyc < cyc) begin chk("err_cycle", cyc, errq[0].cyc); errq.delete(0); end
        if (rd_valid) begin
            if (rdq.size() == 0) chk("rd_extra", 1, 0);
            else begin
                re = rdq.pop_front();
                chk("rd_cycle", cyc, re.cyc);
                chk("rd_bg", rd_bank_group, re.bg);
                chk("rd_bank", rd_bank, re.bk);
                chk("rd_row", rd_row, re.row);
                chk("rd_col", rd_col, re.col);
            end
        end
        if (wr_ack) begin
            if (wrq.size() == 0) chk("wr_extra", 1, 0);
            else begin
                we = wrq.pop_front();
                chk("wr_cycle", cyc, we.cyc);
                chk("wr_bg", wr_bank_group, we.bg);
                chk("wr_bank", wr_bank, we.bk);
            end
        end
        if (err_valid) begin
            if (errq.size() == 0) chk("err_extra", 1, 0);
            else begin
                ee = errq.pop_front();
                chk("err_cycle", cyc, ee.cyc);
                chk("err_pulse_code", err_code, ee.code);
            end
        end
        chk("open_mask", open_mask, mask_shown);
        chk("err_code_held", err_code, code_shown);
    end

    initial begin
        for (int j = 0; j < 32; j++) begin m_open[j] = 1'b0; m_row[j] = '0; m_ready[j] = 0; end
        do_reset(3);

        // read path: bg=2 bank=1 (bit 9)
        step(1, 3'd0, 5'd9, 16'h1234, 10'd0);
        step(1, 3'd1, 5'd9, 16'h0, 10'd0);
        idle(4);
        step(1, 3'd2, 5'd9, 16'h0, 10'h005);
        step(1, 3'd3, 5'd9, 16'h0, 10'h005);
        idle(8);
        @(negedge clock);
        chk("open_bit9", open_mask[9], 1'b1);

        // RD0 while tRCD still running
        step(1, 3'd0, 5'd2, 16'hbeef, 10'd0);
        step(1, 3'd1, 5'd2, 16'h0, 10'd0);
        idle(1);
        step(1, 3'd2, 5'd2, 16'h0, 10'h3);
        idle(8);

        // ACT0 abandoned
        step(1, 3'd0, 5'd4, 16'h5555, 10'd0);
        idle(3);

        // tRP on bank 0
        step(1, 3'd0, 5'd0, 16'h0abc, 10'd0);
        step(1, 3'd1, 5'd0, 16'h0, 10'd0);
        idle(5);
        step(1, 3'd6, 5'd0, 16'h0, 10'd0);
        idle(1);
        step(1, 3'd0, 5'd0, 16'h0111, 10'd0);
        idle(2);
        step(1, 3'd0, 5'd0, 16'h0222, 10'd0);
        step(1, 3'd1, 5'd0, 16'h0, 10'd0);
        idle(5);

        // REF with an open bank, then after closing all, then tRFC
        step(1, 3'd0, 5'd3, 16'h3333, 10'd0);
        step(1, 3'd1, 5'd3, 16'h0, 10'd0);
        idle(5);
        step(1, 3'd7, 5'd0, 16'h0, 10'd0);
        for (int i = 0; i < 32; i++) step(1, 3'd6, 5'(i), 16'h0, 10'd0);
        step(1, 3'd7, 5'd0, 16'h0, 10'd0);
        step(1, 3'd0, 5'd3, 16'h4444, 10'd0);
        idle(17);
        step(1, 3'd0, 5'd3, 16'h4444, 10'd0);
        step(1, 3'd1, 5'd3, 16'h0, 10'd0);
        idle(5);

        // reads in flight discarded by reset
        step(1, 3'd2, 5'd3, 16'h0, 10'h011);
        step(1, 3'd3, 5'd3, 16'h0, 10'h011);
        step(1, 3'd2, 5'd3, 16'h0, 10'h022);
        step(1, 3'd3, 5'd3, 16'h0, 10'h022);
        idle(2);
        do_reset(2);
        idle(1);
        @(negedge clock);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_rd_col", rd_col, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_open_mask", open_mask, 0);
        idle(10);

        for (int it = 0; it < 600; it++) begin
            int a;
            logic [4:0] bi;
            logic [2:0] k;
            a = $urandom_range(0, 19);
            case (a)
                0, 1, 2, 3: begin
                    bi = pick_bank(1'b0);
                    step(1, 3'd0, bi, 16'($urandom), 10'd0);
                    step(1, 3'd1, bi, 16'($urandom), 10'd0);
                end
                4, 5, 6, 7, 8: begin
                    bi = pick_bank(1'b1);
                    k  = (a < 7) ? 3'd2 : 3'd4;
                    step(1, k, bi, 16'($urandom), 10'($urandom));
                    step(1, k + 3'd1, bi, 16'($urandom), 10'($urandom));
                end
                9:  step(1, 3'd6, pick_bank(1'b1), 16'd0, 10'd0);
                10: if ($urandom_range(0, 3) == 0) step(1, 3'd7, 5'd0, 16'd0, 10'd0); else idle(1);
                11: begin
                    bi = pick_bank(1'b1);
                    k  = 3'(2 * $urandom_range(0, 2));
                    step(1, k, bi, 16'($urandom), 10'($urandom));
                    step(1'($urandom), 3'($urandom), pick_bank(1'b0), 16'($urandom), 10'($urandom));
                end
                12: step(1, 3'($urandom), pick_bank(1'b1), 16'($urandom), 10'($urandom));
                19: if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2)); else idle(1);
                default: idle($urandom_range(1, 5));
            endcase
        end

        idle(40);
        @(negedge clock);
        chk("rdq_drained", rdq.size(), 0);
        chk("wrq_drained", wrq.size(), 0);
        chk("errq_drained", errq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr5_cmd_receiver.md
DDR5_CMD_RECEIVER -- requirements
Module: ddr5_cmd_receiver

Interface
REQ-001 SHALL have parameter TRCD, default 4: cycles from accepted ACT1 until RD0/WR0 is legal to the same bank.
REQ-002 SHALL have parameter TRP, default 4: cycles from accepted PRE until ACT0 is legal to the same bank.
REQ-003 SHALL have parameter TRFC, default 16: cycles from accepted REF until ACT0 is legal to any bank.
REQ-004 SHALL have parameter TCL, default 6: cycles from accepted RD1 to the rd_valid pulse.
REQ-005 SHALL have parameter TCWL, default 4: cycles from accepted WR1 to the wr_ack pulse.
REQ-006 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port cmd_valid, input, 1: cmd and address fields are valid this cycle.
REQ-009 SHALL have port cmd, input, 3: ACT0=0, ACT1=1, RD0=2, RD1=3, WR0=4, WR1=5, PRE=6, REF=7.
REQ-010 SHALL have port bank_group, input, 3: target bank group.
REQ-011 SHALL have port bank, input, 2: target bank within the group.
REQ-012 SHALL have port row, input, 16: row address, sampled on ACT0 only.
REQ-013 SHALL have port col, input, 10: column address, sampled on RD0/WR0 only.
REQ-014 SHALL have port open_mask, output, 32: bit {bank_group,bank} = 1 when that bank is open.
REQ-015 SHALL have ports rd_valid (output, 1), rd_bank_group (output, 3), rd_bank (output, 2), rd_row (output, 16), rd_col (output, 10): read response.
REQ-016 SHALL have ports wr_ack (output, 1), wr_bank_group (output, 3), wr_bank (output, 2): write completion.
REQ-017 SHALL have ports err_valid (output, 1) and err_code (output, 3): protocol/timing violation report.

Function
REQ-018 SHALL decode with FSM states IDLE, WAIT_ACT1, WAIT_RD1, WAIT_WR1.
REQ-019 IDLE: ACT0 -> WAIT_ACT1 latching bg/bank/row; RD0 -> WAIT_RD1 latching bg/bank/col; WR0 -> WAIT_WR1 latching bg/bank/col; PRE/REF executed in the same cycle, stay IDLE.
REQ-020 WAIT_x: matching second half (ACT1/RD1/WR1) on the next cycle with the same bg/bank executes the command, -> IDLE.
REQ-021 WAIT_x with cmd_valid=0, a different cmd, or a bg/bank mismatch: err_code=1 (protocol), the command and the incoming cmd are both dropped, -> IDLE.
REQ-022 IDLE receiving ACT1/RD1/WR1: err_code=1, dropped.
REQ-023 ACT0 to an open bank: err_code=2; ACT0 while that bank's timer is nonzero: err_code=5; on error, no transition out of IDLE.
REQ-024 RD0/WR0 to a closed bank: err_code=3; RD0/WR0 whose latched row differs from the open row is not possible since column commands carry no row and are not checked against it; RD0/WR0 with timer nonzero: err_code=4; on error, no transition.
REQ-025 REF with any bank open: err_code=6, dropped; PRE to a closed bank is a legal no-op.
REQ-026 Error priority when several apply: 1, 2/3, 4/5, 6 (lowest code first).
REQ-027 Executed ACT1: set open bit, store row, load bank timer with TRCD.
REQ-028 Executed PRE: clear open bit, load bank timer with TRP.
REQ-029 Executed REF: load all 32 timers with TRFC.
REQ-030 Timers SHALL decrement by 1 per cycle, saturating at 0; a load in the same cycle overrides the decrement.
REQ-031 Executed RD1: push {bg, bank, stored row, col} into a TCL-deep delay line; rd_valid pulses exactly TCL cycles after the RD1 cycle.
REQ-032 Executed WR1: wr_ack pulses exactly TCWL cycles after the WR1 cycle with its bg/bank.
REQ-033 Delay lines SHALL accept one entry per cycle, so back-to-back reads produce back-to-back rd_valid pulses.
REQ-034 err_valid SHALL be a one-cycle pulse, registered, one cycle after the offending input; err_code is held until the next error.
REQ-035 rd_* and wr_* fields are don't-care when their valid bit is 0.

Reset
REQ-036 While reset=1: FSM=IDLE, open_mask=0, all timers=0, delay lines emptied, rd_valid=0, wr_ack=0, err_valid=0, err_code=0.
REQ-037 Reset during WAIT_x or with responses in flight SHALL discard them; no pulses after reset deasserts.

Verification
REQ-038 ACT0/ACT1 bg=2,bank=1,row=0x1234; wait 4; RD0/RD1 col=0x05 -> open_mask bit 9=1; rd_valid 6 cycles after RD1 with row 0x1234, col 0x05.
REQ-039 ACT0/ACT1 then RD0 2 cycles after ACT1 -> err_valid, err_code=4; no rd_valid.
REQ-040 ACT0 followed by idle cycle -> err_code=1, open_mask unchanged, FSM IDLE.
REQ-041 PRE bank 0, ACT0 bank 0 after 2 cycles -> err_code=5; ACT0 after 4 cycles -> accepted.
REQ-042 REF with bank 3 open -> err_code=6; after PRE, REF accepted; ACT0 within 16 cycles -> err_code=5.
REQ-043 Two RD pairs back-to-back then reset asserted 3 cycles later -> no rd_valid ever, all outputs 0.
